fifo_ctrl: RTL

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_if.sv | 35 +++
 rtl/fifo_ptr.sv | 22 ++
 rtl/fifo_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller slice: FSM state encoding,
// default geometry and small sizing helpers.
package fifo_pkg;

    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MID   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/fifo_if.sv
// Producer/consumer handshake and status bundle between the FIFO controller
// and its users; the controller owns the slave side.
interface fifo_if #(
    parameter int ADDR_W = fifo_pkg::ADDR_W_DEF
) ();

    logic              wr_req;
    logic              rd_req;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_req, rd_req,
        input  wr_en, wr_addr, rd_addr, rd_valid,
        input  full, empty, almost_full, almost_empty,
        input  count, overflow, underflow
    );

    modport slave (
        input  wr_req, rd_req,
        output wr_en, wr_addr, rd_addr, rd_valid,
        output full, empty, almost_full, almost_empty,
        output count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping pointer: W-bit incrementer with enable; the MSB acts as the wrap
// bit so that equal low bits can be told apart as empty or full.
module fifo_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] ptr
);

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller for an external DFF storage array: pointer management,
// occupancy FSM, threshold flags and one-cycle error pulses.
module fifo_ctrl import fifo_pkg::*; #(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2
) (
    input  logic   clk,
    input  logic   rst,
    fifo_if.slave  bus
);

    localparam int              DEPTH      = depth_of(ADDR_W);
    localparam int              PW         = ADDR_W + 1;
    localparam logic [ADDR_W:0] LAST_CNT   = PW'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_CNT    = PW'(1);
    localparam logic [ADDR_W:0] AFULL_CNT  = PW'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_CNT = PW'(AEMPTY_TH);

    state_t          state;
    state_t          state_nx;
    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] rptr;
    logic [ADDR_W:0] cnt;
    logic            is_full;
    logic            is_empty;
    logic            wr_acc;
    logic            rd_acc;
    logic            rd_valid_q;
    logic            overflow_q;
    logic            underflow_q;

    // Flags come from the FSM, so a request never races an arithmetic compare.
    assign is_full  = (state == ST_FULL);
    assign is_empty = (state == ST_EMPTY);
    assign wr_acc   = bus.wr_req & ~is_full;
    assign rd_acc   = bus.rd_req & ~is_empty;
    assign cnt      = wptr - rptr;

    fifo_ptr #(.W(PW)) u_wptr (
        .clk (clk),
        .rst (rst),
        .en  (wr_acc),
        .ptr (wptr)
    );

    fifo_ptr #(.W(PW)) u_rptr (
        .clk (clk),
        .rst (rst),
        .en  (rd_acc),
        .ptr (rptr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: state_nx gets its default before the case so that no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            ST_EMPTY: begin
                if (wr_acc) begin
                    state_nx = ST_MID;
                end
            end
            ST_MID: begin
                if (wr_acc && !rd_acc && cnt == LAST_CNT) begin
                    state_nx = ST_FULL;
                end else if (rd_acc && !wr_acc && cnt == ONE_CNT) begin
                    state_nx = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (rd_acc) begin
                    state_nx = ST_MID;
                end
            end
            default: state_nx = ST_EMPTY;
        endcase
    end

    // Rejected requests leave the pointers alone and report one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_valid_q  <= rd_acc;
            overflow_q  <= bus.wr_req & is_full;
            underflow_q <= bus.rd_req & is_empty;
        end
    end

    assign bus.wr_en        = wr_acc;
    assign bus.wr_addr      = wptr[ADDR_W-1:0];
    assign bus.rd_addr      = rptr[ADDR_W-1:0];
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.almost_full  = (cnt >= AFULL_CNT);
    assign bus.almost_empty = (cnt <= AEMPTY_CNT);
    assign bus.count        = cnt;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
